// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer with out-of-order
// writeback, branch mispredict flush and optional retired-instruction counter.
// Optional feature macro: ROB_COMMIT_CNT_EN (enables the commit_cnt register).
module reorder_buffer #(
   parameter int ROB_SIZE = 16,
   parameter int TAG_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              issue_valid,
   input  logic [4:0]        issue_rd,
   input  logic              issue_is_br,
   input  logic              issue_pred,
   output logic [TAG_W-1:0]  issue_tag,
   output logic              full,
   input  logic              wb_valid,
   input  logic [TAG_W-1:0]  wb_tag,
   input  logic [31:0]       wb_value,
   input  logic              wb_taken,
   output logic              commit_valid,
   output logic [4:0]        commit_rd,
   output logic [31:0]       commit_value,
   output logic [TAG_W-1:0]  commit_tag,
   output logic              flush,
   output logic [31:0]       flush_pc,
   output logic [31:0]       commit_cnt
);

   localparam logic [TAG_W:0] LP_SIZE = (TAG_W+1)'(ROB_SIZE);

   logic [TAG_W-1:0] r_head;
   logic [TAG_W-1:0] r_tail;
   logic [TAG_W:0]   r_count;

   // Per-entry payload kept in plain arrays (no reset needed: busy gates use)
   logic [4:0]       r_rd    [ROB_SIZE];
   logic [31:0]      r_value [ROB_SIZE];

   // Per-entry flags gathered from the generate blocks below
   logic [ROB_SIZE-1:0] w_busy;
   logic [ROB_SIZE-1:0] w_ready;
   logic [ROB_SIZE-1:0] w_is_br;
   logic [ROB_SIZE-1:0] w_pred;
   logic [ROB_SIZE-1:0] w_taken;

   logic w_alloc;
   logic w_commit;
   logic w_mispredict;
   logic w_wb;

   assign issue_tag = r_tail;
   assign full      = (r_count == LP_SIZE);

   // Datapath qualifiers; full comes from the registered count, so a
   // commit cannot open a slot for an allocate in the same cycle.
   always_comb begin
      w_alloc      = rdy & issue_valid & ~full;
      w_commit     = rdy & w_busy[r_head] & w_ready[r_head];
      w_mispredict = w_commit & w_is_br[r_head] & (w_taken[r_head] != w_pred[r_head]);
      w_wb         = rdy & wb_valid & w_busy[wb_tag];
   end

   // Per-entry status flags. Allocate only targets a non-busy slot and
   // writeback only a busy one, so they never collide on the same entry.
   for (genvar gi = 0; gi < ROB_SIZE; gi++) begin : gen_entry
      localparam logic [TAG_W-1:0] LP_IDX = TAG_W'(gi);
      logic r_busy;
      logic r_ready;
      logic r_is_br;
      logic r_pred;
      logic r_taken;

      // Flag update: flush clears everything, otherwise alloc/commit/wb
      always_ff @(posedge clk) begin
         if (rst) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_is_br <= 1'b0;
            r_pred  <= 1'b0;
            r_taken <= 1'b0;
         end else if (rdy) begin
            if (w_mispredict) begin
               r_busy  <= 1'b0;
               r_ready <= 1'b0;
            end else begin
               if (w_alloc && (r_tail == LP_IDX)) begin
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
                  r_is_br <= issue_is_br;
                  r_pred  <= issue_pred;
               end else if (w_commit && (r_head == LP_IDX)) begin
                  r_busy  <= 1'b0;
                  r_ready <= 1'b0;
               end
               if (w_wb && (wb_tag == LP_IDX) && !(w_commit && (r_head == LP_IDX))) begin
                  r_ready <= 1'b1;
                  r_taken <= wb_taken;
               end
            end
         end
      end

      assign w_busy[gi]  = r_busy;
      assign w_ready[gi] = r_ready;
      assign w_is_br[gi] = r_is_br;
      assign w_pred[gi]  = r_pred;
      assign w_taken[gi] = r_taken;
   end

   // Payload writes; dropped during a flush cycle
   always_ff @(posedge clk) begin
      if (!rst && rdy && !w_mispredict) begin
         if (w_alloc) begin
            r_rd[r_tail] <= issue_rd;
         end
         if (w_wb) begin
            r_value[wb_tag] <= wb_value;
         end
      end
   end

   // Head/tail/count bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (rdy) begin
         if (w_mispredict) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_alloc) begin
               r_tail <= r_tail + 1'b1;
            end
            if (w_commit) begin
               r_head <= r_head + 1'b1;
            end
            case ({w_alloc, w_commit})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Registered retirement outputs; pulses drop in any non-commit cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         commit_valid <= 1'b0;
         commit_rd    <= '0;
         commit_value <= '0;
         commit_tag   <= '0;
         flush        <= 1'b0;
         flush_pc     <= '0;
      end else if (rdy) begin
         commit_valid <= w_commit;
         flush        <= w_mispredict;
         if (w_commit) begin
            commit_rd    <= w_is_br[r_head] ? 5'd0 : r_rd[r_head];
            commit_value <= r_value[r_head];
            commit_tag   <= r_head;
         end
         if (w_mispredict) begin
            flush_pc <= r_value[r_head];
         end
      end else begin
         commit_valid <= 1'b0;
         flush        <= 1'b0;
      end
   end

`ifdef ROB_COMMIT_CNT_EN
   logic [31:0] r_commit_cnt;

   // Retired-instruction counter, wraps naturally at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         r_commit_cnt <= '0;
      end else if (w_commit) begin
         r_commit_cnt <= r_commit_cnt + 32'd1;
      end
   end

   assign commit_cnt = r_commit_cnt;
`else
   assign commit_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer; checks all go through one task.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_is_br;
   logic        issue_pred;
   logic [3:0]  issue_tag;
   logic        full;
   logic        wb_valid;
   logic [3:0]  wb_tag;
   logic [31:0] wb_value;
   logic        wb_taken;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [31:0] commit_value;
   logic [3:0]  commit_tag;
   logic        flush;
   logic [31:0] flush_pc;
   logic [31:0] commit_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulses;

   reorder_buffer #(.ROB_SIZE(16), .TAG_W(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
      .issue_pred(issue_pred), .issue_tag(issue_tag), .full(full),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_taken(wb_taken),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
      .commit_tag(commit_tag), .flush(flush), .flush_pc(flush_pc), .commit_cnt(commit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic alloc(input logic [4:0] rd, input logic br, input logic pred);
      issue_valid = 1'b1; issue_rd = rd; issue_is_br = br; issue_pred = pred;
      tick();
      issue_valid = 1'b0; issue_is_br = 1'b0; issue_pred = 1'b0;
   endtask

   task automatic wb(input logic [3:0] tag, input logic [31:0] val, input logic tk);
      wb_valid = 1'b1; wb_tag = tag; wb_value = val; wb_taken = tk;
      tick();
      wb_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_is_br = 1'b0;
      issue_pred = 1'b0; wb_valid = 1'b0; wb_tag = '0; wb_value = '0; wb_taken = 1'b0;

      // Reset state
      tick();
      rst = 1'b0;
      check("rst_commit_valid", 32'(commit_valid), 32'd0);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_issue_tag", 32'(issue_tag), 32'd0);
      check("rst_commit_value", commit_value, 32'd0);
      check("rst_flush_pc", flush_pc, 32'd0);
      check("rst_commit_cnt", commit_cnt, 32'd0);

      // Fill to 16 entries, then an ignored 17th
      for (int i = 0; i < 16; i++) begin
         check($sformatf("fill_tag%0d", i), 32'(issue_tag), 32'(i));
         alloc(5'(i + 1), 1'b0, 1'b0);
      end
      check("fill_full", 32'(full), 32'd1);
      alloc(5'd20, 1'b0, 1'b0);
      check("over_full", 32'(full), 32'd1);
      check("over_tail", 32'(issue_tag), 32'd0);

      // Full buffer, head ready, issue held: commit, refuse, then accept
      wb(4'd0, 32'hA, 1'b0);
      check("fullc_nocommit_yet", 32'(commit_valid), 32'd0);
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      check("fullc_commit_valid", 32'(commit_valid), 32'd1);
      check("fullc_commit_tag", 32'(commit_tag), 32'd0);
      check("fullc_commit_value", commit_value, 32'hA);
      check("fullc_commit_rd", 32'(commit_rd), 32'd1);
      check("fullc_refused_tail", 32'(issue_tag), 32'd0);
      check("fullc_not_full", 32'(full), 32'd0);
      tick();
      issue_valid = 1'b0;
      check("fullc_accept_tail", 32'(issue_tag), 32'd1);
      check("fullc_full_again", 32'(full), 32'd1);
      check("fullc_pulse_drop", 32'(commit_valid), 32'd0);

      // Out-of-order writeback, in-order commit
      do_reset();
      alloc(5'd1, 1'b0, 1'b0);
      alloc(5'd2, 1'b0, 1'b0);
      alloc(5'd3, 1'b0, 1'b0);
      wb(4'd2, 32'h30, 1'b0);
      check("ooo_wait0", 32'(commit_valid), 32'd0);
      wb(4'd0, 32'h10, 1'b0);
      check("ooo_wait1", 32'(commit_valid), 32'd0);
      wb(4'd1, 32'h20, 1'b0);
      check("ooo_c0_valid", 32'(commit_valid), 32'd1);
      check("ooo_c0_tag", 32'(commit_tag), 32'd0);
      check("ooo_c0_value", commit_value, 32'h10);
      check("ooo_c0_rd", 32'(commit_rd), 32'd1);
      tick();
      check("ooo_c1_valid", 32'(commit_valid), 32'd1);
      check("ooo_c1_tag", 32'(commit_tag), 32'd1);
      check("ooo_c1_value", commit_value, 32'h20);
      tick();
      check("ooo_c2_valid", 32'(commit_valid), 32'd1);
      check("ooo_c2_tag", 32'(commit_tag), 32'd2);
      check("ooo_c2_value", commit_value, 32'h30);
      tick();
      check("ooo_idle", 32'(commit_valid), 32'd0);
      check("ooo_tail", 32'(issue_tag), 32'd3);

      // Mispredicted branch: flush, same-cycle allocate dropped
      do_reset();
      alloc(5'd9, 1'b1, 1'b0);
      wb(4'd0, 32'h1000, 1'b1);
      issue_valid = 1'b1; issue_rd = 5'd4;
      tick();
      issue_valid = 1'b0;
      check("mis_flush", 32'(flush), 32'd1);
      check("mis_flush_pc", flush_pc, 32'h1000);
      check("mis_commit_valid", 32'(commit_valid), 32'd1);
      check("mis_commit_rd", 32'(commit_rd), 32'd0);
      check("mis_next_tag", 32'(issue_tag), 32'd0);
      check("mis_full", 32'(full), 32'd0);
      tick();
      check("mis_flush_drop", 32'(flush), 32'd0);
      check("mis_valid_drop", 32'(commit_valid), 32'd0);

      // Correctly predicted branch: no flush, rd forced to 0
      alloc(5'd4, 1'b1, 1'b1);
      wb(4'd0, 32'h2000, 1'b1);
      tick();
      check("okbr_commit_valid", 32'(commit_valid), 32'd1);
      check("okbr_flush", 32'(flush), 32'd0);
      check("okbr_commit_rd", 32'(commit_rd), 32'd0);
      check("okbr_tail", 32'(issue_tag), 32'd1);

      // rdy low for 3 cycles with head ready
      do_reset();
      alloc(5'd6, 1'b0, 1'b0);
      wb(4'd0, 32'h77, 1'b0);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("stall%0d_commit", i), 32'(commit_valid), 32'd0);
      end
      rdy = 1'b1;
      tick();
      check("stall_release_valid", 32'(commit_valid), 32'd1);
      check("stall_release_value", commit_value, 32'h77);
      check("stall_release_rd", 32'(commit_rd), 32'd6);

      // Reset mid-operation discards a pending commit
      do_reset();
      alloc(5'd3, 1'b0, 1'b0);
      wb(4'd0, 32'h55, 1'b0);
      do_reset();
      check("midrst_valid", 32'(commit_valid), 32'd0);
      tick();
      check("midrst_valid_next", 32'(commit_valid), 32'd0);
      check("midrst_tail", 32'(issue_tag), 32'd0);

      // Five commits for the retired-instruction counter
      for (int i = 0; i < 5; i++) alloc(5'(i + 1), 1'b0, 1'b0);
      n_pulses = 0;
      for (int i = 0; i < 5; i++) begin
         wb(4'(i), 32'(i + 100), 1'b0);
         if (commit_valid) n_pulses++;
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (commit_valid) n_pulses++;
      end
      check("cnt_pulses", 32'(n_pulses), 32'd5);
      check("cnt_last_value", commit_value, 32'd104);
`ifdef ROB_COMMIT_CNT_EN
      check("cnt_value", commit_cnt, 32'd5);
`else
      check("cnt_value", commit_cnt, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
